// File: rtl/tl45_hazard_ctrl_pkg.sv
// tl45_hazard_ctrl_pkg
//  Shared definitions for the tl45 hazard/sequencing controller:
//   - opcode encodings seen in the decode output buffer (OP_BUBBLE marks an empty slot)
//   - haz_state_t : controller sequencing state (RUN, DRAIN, HALTED)
//   - writes_dr() : true for opcodes that write their destination register
package tl45_hazard_ctrl_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_NAND   = 4'h1;
   localparam logic [3:0] OP_ADDI   = 4'h2;
   localparam logic [3:0] OP_LW     = 4'h3;
   localparam logic [3:0] OP_SW     = 4'h4;
   localparam logic [3:0] OP_SKP    = 4'h5;
   localparam logic [3:0] OP_JALR   = 4'h6;
   localparam logic [3:0] OP_HALT   = 4'h7;
   localparam logic [3:0] OP_LEA    = 4'h8;
   localparam logic [3:0] OP_GOTO   = 4'h9;
   localparam logic [3:0] OP_BUBBLE = 4'hF;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } haz_state_t;

   function automatic logic writes_dr(input logic [3:0] opcode);
      return (opcode == OP_ADD)  || (opcode == OP_NAND) || (opcode == OP_ADDI) ||
             (opcode == OP_LW)   || (opcode == OP_JALR) || (opcode == OP_LEA);
   endfunction

endpackage

// File: rtl/tl45_hazard_ctrl_if.sv
// tl45_hazard_ctrl_if
//  Bundle between the pipeline (master) and the hazard controller (slave).
//  Pipeline -> controller : i_dec_opcode/dr/sr1/sr2 (decode buffer contents),
//                           i_wb_valid/i_wb_dr (writeback retire), i_br_taken, i_mem_busy
//  Controller -> pipeline : o_stall_fetch, o_stall_decode, o_flush_decode, o_bubble_execute,
//                           o_halted, o_perf_stall_cnt, o_perf_flush_cnt
interface tl45_hazard_ctrl_if;
   import tl45_hazard_ctrl_pkg::*;

   logic [3:0]  i_dec_opcode;
   logic [3:0]  i_dec_dr;
   logic [3:0]  i_dec_sr1;
   logic [3:0]  i_dec_sr2;
   logic        i_wb_valid;
   logic [3:0]  i_wb_dr;
   logic        i_br_taken;
   logic        i_mem_busy;
   logic        o_stall_fetch;
   logic        o_stall_decode;
   logic        o_flush_decode;
   logic        o_bubble_execute;
   logic        o_halted;
   logic [31:0] o_perf_stall_cnt;
   logic [31:0] o_perf_flush_cnt;

   modport master (
      output i_dec_opcode, i_dec_dr, i_dec_sr1, i_dec_sr2, i_wb_valid, i_wb_dr,
             i_br_taken, i_mem_busy,
      input  o_stall_fetch, o_stall_decode, o_flush_decode, o_bubble_execute, o_halted,
             o_perf_stall_cnt, o_perf_flush_cnt
   );

   modport slave (
      input  i_dec_opcode, i_dec_dr, i_dec_sr1, i_dec_sr2, i_wb_valid, i_wb_dr,
             i_br_taken, i_mem_busy,
      output o_stall_fetch, o_stall_decode, o_flush_decode, o_bubble_execute, o_halted,
             o_perf_stall_cnt, o_perf_flush_cnt
   );

endinterface

// File: rtl/tl45_hazard_ctrl_scoreboard.sv
// tl45_hazard_ctrl_scoreboard
//  16 per-register in-flight write counters, SB_CNT_W bits each.
//  Ports: i_clk, i_reset (sync, active-high), inc_en_i/inc_idx_i (write issued),
//         dec_en_i/dec_idx_i (write retired), busy_o (count!=0), full_o (count==max),
//         all_clear_o (no writes in flight).
module tl45_hazard_ctrl_scoreboard
   import tl45_hazard_ctrl_pkg::*;
#(
   parameter int SB_CNT_W = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        inc_en_i,
   input  logic [3:0]  inc_idx_i,
   input  logic        dec_en_i,
   input  logic [3:0]  dec_idx_i,
   output logic [15:0] busy_o,
   output logic [15:0] full_o,
   output logic        all_clear_o
);

   localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);
   localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

   for (genvar gi = 0; gi < 16; gi++) begin : g_cnt
      logic [SB_CNT_W-1:0] cnt_q, cnt_d;
      logic inc_hit, dec_req, dec_hit;

      assign inc_hit = inc_en_i && (inc_idx_i == 4'(gi));
      assign dec_req = dec_en_i && (dec_idx_i == 4'(gi));
      // A retire against an empty counter (stale writeback after reset) is dropped.
      assign dec_hit = dec_req && (cnt_q != '0);

      always_comb begin
         cnt_d = cnt_q;
         if (inc_hit && !dec_hit)
            cnt_d = cnt_q + CNT_ONE;
         else if (!inc_hit && dec_hit)
            cnt_d = cnt_q - CNT_ONE;
      end

      always_ff @(posedge i_clk) begin
         if (i_reset) cnt_q <= '0;
         else         cnt_q <= cnt_d;
      end

      assign busy_o[gi] = (cnt_q != '0);
      assign full_o[gi] = (cnt_q == CNT_MAX);

      a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
                                       !(dec_req && cnt_q == '0));
   end

   assign all_clear_o = ~|busy_o;

endmodule

// File: rtl/tl45_hazard_ctrl.sv
// tl45_hazard_ctrl
//  Pipeline sequencer beside decode: RAW-hazard stall/bubble via a write scoreboard,
//  taken-branch flush sequencing, and HALT drain.
//  Ports: i_clk, i_reset (sync, active-high), haz_if (tl45_hazard_ctrl_if.slave).
//  Parameters: SB_CNT_W (in-flight counter width), FLUSH_CYCLES (flush hold after a redirect).
//  Optional macro TL45_HAZ_PERF_EN: enables the 32-bit stall/flush performance counters;
//  otherwise both perf outputs are constant zero.
module tl45_hazard_ctrl
   import tl45_hazard_ctrl_pkg::*;
#(
   parameter int SB_CNT_W     = 2,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   tl45_hazard_ctrl_if.slave  haz_if
);

   localparam int              FC_W    = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);
   localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

   haz_state_t      state_q, state_d;
   logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [15:0]     sb_busy, sb_full;
   logic            sb_all_clear;
   logic            run, dec_valid, dec_writes, hazard, br_accept, flushing, issue, wb_dec;

   assign run        = (state_q == RUN);
   assign dec_valid  = (haz_if.i_dec_opcode != OP_BUBBLE);
   assign dec_writes = writes_dr(haz_if.i_dec_opcode) && (haz_if.i_dec_dr != 4'd0);

   // A full destination counter is also a hazard: one more write would overflow it.
   assign hazard = dec_valid &&
                   (((haz_if.i_dec_sr1 != 4'd0) && sb_busy[haz_if.i_dec_sr1]) ||
                    ((haz_if.i_dec_sr2 != 4'd0) && sb_busy[haz_if.i_dec_sr2]) ||
                    (dec_writes && sb_full[haz_if.i_dec_dr]));

   // Redirects are only meaningful while running; the flush starts the same cycle.
   assign br_accept = haz_if.i_br_taken && run;
   assign flushing  = br_accept || (flush_cnt_q != '0);
   assign issue     = dec_valid && run && !hazard && !haz_if.i_mem_busy && !flushing;
   assign wb_dec    = haz_if.i_wb_valid && (haz_if.i_wb_dr != 4'd0);

   tl45_hazard_ctrl_scoreboard #(.SB_CNT_W(SB_CNT_W)) u_sb (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .inc_en_i    (issue && dec_writes),
      .inc_idx_i   (haz_if.i_dec_dr),
      .dec_en_i    (wb_dec),
      .dec_idx_i   (haz_if.i_wb_dr),
      .busy_o      (sb_busy),
      .full_o      (sb_full),
      .all_clear_o (sb_all_clear)
   );

   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (br_accept)
         flush_cnt_d = FC_LOAD;
      else if (flush_cnt_q != '0)
         flush_cnt_d = flush_cnt_q - FC_ONE;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (issue && haz_if.i_dec_opcode == OP_HALT) state_d = DRAIN;
         DRAIN:   if (sb_all_clear && !haz_if.i_mem_busy)      state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Flush wins over a hazard stall: the stalled instruction is being squashed anyway.
   assign haz_if.o_stall_decode   = !run || haz_if.i_mem_busy || (hazard && !flushing);
   assign haz_if.o_stall_fetch    = haz_if.o_stall_decode;
   assign haz_if.o_flush_decode   = flushing;
   assign haz_if.o_bubble_execute = hazard && run && !haz_if.i_mem_busy && !flushing;
   assign haz_if.o_halted         = (state_q == HALTED);

   a_no_br_when_stopped: assert property (@(posedge i_clk) disable iff (i_reset)
                                          !(haz_if.i_br_taken && !run));

`ifdef TL45_HAZ_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (haz_if.o_bubble_execute) perf_stall_q <= perf_stall_q + 32'd1;
         if (br_accept)               perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign haz_if.o_perf_stall_cnt = perf_stall_q;
   assign haz_if.o_perf_flush_cnt = perf_flush_q;
`else
   assign haz_if.o_perf_stall_cnt = 32'h0;
   assign haz_if.o_perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_tl45_hazard_ctrl.sv
// tb_tl45_hazard_ctrl
//  Table-driven bench for tl45_hazard_ctrl (SB_CNT_W=2, FLUSH_CYCLES=2). Each vector's expected
//  outputs are queued when the vector is driven and popped when the outputs are sampled.
module tb_tl45_hazard_ctrl;
   import tl45_hazard_ctrl_pkg::*;

`ifdef TL45_HAZ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // expected {stall, flush, bubble, halted}
   localparam logic [3:0] E_IDLE  = 4'b0000;
   localparam logic [3:0] E_HAZ   = 4'b1010;
   localparam logic [3:0] E_FRZ   = 4'b1000;
   localparam logic [3:0] E_FLUSH = 4'b0100;
   localparam logic [3:0] E_HALT  = 4'b1001;
   localparam logic [3:0] BUB     = 4'hF;

   typedef struct {
      string      nm;
      logic       rst;
      logic [3:0] op, dr, sr1, sr2;
      logic       wbv;
      logic [3:0] wbd;
      logic       br, mb;
      logic [3:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   check_cnt = 0;
   int   pass_cnt  = 0;
   vec_t vecs[$];
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   tl45_hazard_ctrl_if hif();

   tl45_hazard_ctrl #(.SB_CNT_W(2), .FLUSH_CYCLES(2)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .haz_if  (hif)
   );

   task automatic add(input string nm, input logic r, input logic [3:0] op, dr, sr1, sr2,
                      input logic wbv, input logic [3:0] wbd, input logic br, mb,
                      input logic [3:0] exp);
      vec_t v;
      v.nm = nm; v.rst = r; v.op = op; v.dr = dr; v.sr1 = sr1; v.sr2 = sr2;
      v.wbv = wbv; v.wbd = wbd; v.br = br; v.mb = mb; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      rst               = v.rst;
      hif.i_dec_opcode  = v.op;
      hif.i_dec_dr      = v.dr;
      hif.i_dec_sr1     = v.sr1;
      hif.i_dec_sr2     = v.sr2;
      hif.i_wb_valid    = v.wbv;
      hif.i_wb_dr       = v.wbd;
      hif.i_br_taken    = v.br;
      hif.i_mem_busy    = v.mb;
   endtask

   task automatic run_vecs();
      logic [3:0] e;
      logic [4:0] got, want;
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         drive(vecs[i]);
         exp_q.push_back(vecs[i].exp);
         @(negedge clk);
         e    = exp_q.pop_front();
         got  = {hif.o_stall_fetch, hif.o_stall_decode, hif.o_flush_decode,
                 hif.o_bubble_execute, hif.o_halted};
         want = {e[3], e};
         check_cnt++;
         if (got === want) begin
            pass_cnt++;
            $display("vec %s: sf,sd,fl,bu,ha=%b ok", vecs[i].nm, got);
         end else begin
            $display("FAIL vec %s: sf,sd,fl,bu,ha got %b want %b", vecs[i].nm, got, want);
         end
      end
      vecs.delete();
   endtask

   task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
      check_cnt++;
      if (got === want) begin
         pass_cnt++;
         $display("chk %s: %0d ok", nm, got);
      end else begin
         $display("FAIL chk %s: got %0d want %0d", nm, got, want);
      end
   endtask

   initial begin
      rst = 1'b1;
      hif.i_dec_opcode = BUB; hif.i_dec_dr = 0; hif.i_dec_sr1 = 0; hif.i_dec_sr2 = 0;
      hif.i_wb_valid = 0; hif.i_wb_dr = 0; hif.i_br_taken = 0; hif.i_mem_busy = 0;

      // ---------------- phase A ----------------
      //   name          rst op       dr sr1 sr2 wbv wbd br mb exp
      add("reset",       1, BUB,     0, 0, 0, 0, 0, 0, 0, E_IDLE);
      // RAW on R1 until its writeback retires
      add("t1_addi_r1",  0, OP_ADDI, 1, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t1_raw_a",    0, OP_ADD,  2, 1, 3, 0, 0, 0, 0, E_HAZ);
      add("t1_raw_b",    0, OP_ADD,  2, 1, 3, 0, 0, 0, 0, E_HAZ);
      add("t1_raw_wb",   0, OP_ADD,  2, 1, 3, 1, 1, 0, 0, E_HAZ);
      add("t1_issue",    0, OP_ADD,  2, 1, 3, 0, 0, 0, 0, E_IDLE);
      add("t1_wb_r2",    0, BUB,     0, 0, 0, 1, 2, 0, 0, E_IDLE);
      // R0 is never tracked
      add("t2_r0_a",     0, OP_ADD,  0, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t2_r0_b",     0, OP_ADD,  0, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t2_r0_c",     0, OP_ADD,  0, 0, 0, 0, 0, 0, 0, E_IDLE);
      // taken branch over a pending RAW: flush this cycle + FLUSH_CYCLES more
      add("t3_addi_r4",  0, OP_ADDI, 4, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t3_br",       0, OP_ADD,  5, 4, 0, 0, 0, 1, 0, E_FLUSH);
      add("t3_flush_2",  0, OP_ADD,  5, 4, 0, 0, 0, 0, 0, E_FLUSH);
      add("t3_flush_1",  0, OP_ADD,  5, 4, 0, 0, 0, 0, 0, E_FLUSH);
      add("t3_post_haz", 0, OP_ADD,  5, 4, 0, 0, 0, 0, 0, E_HAZ);
      add("t3_wb_r4",    0, BUB,     0, 0, 0, 1, 4, 0, 0, E_IDLE);
      add("t3_r5_clean", 0, OP_ADD,  6, 5, 0, 0, 0, 0, 0, E_IDLE);
      add("t3_wb_r6",    0, BUB,     0, 0, 0, 1, 6, 0, 0, E_IDLE);
      // counter saturation on R5 (max 3 in flight)
      add("t4_w1",       0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t4_w2",       0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t4_w3",       0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t4_w4_full",  0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_HAZ);
      add("t4_w4_membsy",0, OP_ADDI, 5, 0, 0, 0, 0, 0, 1, E_FRZ);
      add("t4_w4_wb",    0, OP_ADDI, 5, 0, 0, 1, 5, 0, 0, E_HAZ);
      add("t4_w4_issue", 0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t4_drain_a",  0, BUB,     0, 0, 0, 1, 5, 0, 0, E_IDLE);
      add("t4_drain_b",  0, BUB,     0, 0, 0, 1, 5, 0, 0, E_IDLE);
      add("t4_drain_c",  0, BUB,     0, 0, 0, 1, 5, 0, 0, E_IDLE);
      // same-register inc+dec nets to zero change
      add("t4_n1",       0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t4_n_incdec", 0, OP_ADDI, 5, 0, 0, 1, 5, 0, 0, E_IDLE);
      add("t4_n2",       0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t4_n3",       0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t4_n_full",   0, OP_ADDI, 5, 0, 0, 0, 0, 0, 0, E_HAZ);
      add("t4_n_wb_a",   0, BUB,     0, 0, 0, 1, 5, 0, 0, E_IDLE);
      add("t4_n_wb_b",   0, BUB,     0, 0, 0, 1, 5, 0, 0, E_IDLE);
      add("t4_n_wb_c",   0, BUB,     0, 0, 0, 1, 5, 0, 0, E_IDLE);
      // HALT drain with a pending write and a busy memory stage
      add("t5_addi_r4",  0, OP_ADDI, 4, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t5_halt",     0, OP_HALT, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
      add("t5_drain_mb", 0, BUB,     0, 0, 0, 0, 0, 0, 1, E_FRZ);
      add("t5_drain_wb", 0, BUB,     0, 0, 0, 1, 4, 0, 1, E_FRZ);
      add("t5_clear_mb", 0, BUB,     0, 0, 0, 0, 0, 0, 1, E_FRZ);
      add("t5_clear",    0, BUB,     0, 0, 0, 0, 0, 0, 0, E_FRZ);
      add("t5_halted",   0, BUB,     0, 0, 0, 0, 0, 0, 0, E_HALT);
      add("t5_hold",     0, OP_ADD,  1, 2, 3, 0, 0, 0, 0, E_HALT);
      add("t5_rst",      1, BUB,     0, 0, 0, 0, 0, 0, 0, E_HALT);
      add("t5_post_rst", 0, BUB,     0, 0, 0, 0, 0, 0, 0, E_IDLE);
      run_vecs();
      check32("perf_stall_after_rst", hif.o_perf_stall_cnt, 32'd0);
      check32("perf_flush_after_rst", hif.o_perf_flush_cnt, 32'd0);

      // ---------------- phase B: 5 stall cycles, 2 taken branches ----------------
      add("t6_addi_r1",  0, OP_ADDI, 1, 0, 0, 0, 0, 0, 0, E_IDLE);
      for (int k = 0; k < 5; k++)
         add($sformatf("t6_stall_%0d", k), 0, OP_ADD, 2, 1, 0, 0, 0, 0, 0, E_HAZ);
      add("t6_br_a",     0, BUB,     0, 0, 0, 0, 0, 1, 0, E_FLUSH);
      add("t6_br_b",     0, BUB,     0, 0, 0, 0, 0, 1, 0, E_FLUSH);
      add("t6_hold_2",   0, BUB,     0, 0, 0, 0, 0, 0, 0, E_FLUSH);
      add("t6_hold_1",   0, BUB,     0, 0, 0, 1, 1, 0, 0, E_FLUSH);
      add("t6_done",     0, BUB,     0, 0, 0, 0, 0, 0, 0, E_IDLE);
      run_vecs();
      check32("perf_stall_cnt", hif.o_perf_stall_cnt, PERF ? 32'd5 : 32'd0);
      check32("perf_flush_cnt", hif.o_perf_flush_cnt, PERF ? 32'd2 : 32'd0);

      // reset clears the perf counters
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check32("perf_stall_reset", hif.o_perf_stall_cnt, 32'd0);
      check32("perf_flush_reset", hif.o_perf_flush_cnt, 32'd0);
      check32("halted_reset", {31'd0, hif.o_halted}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
